mem_bus_arbiter: RTL

- Two-master, one-slave arbiter that shares the single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between IFU/LSU and the memory/SRAM model. It serialises transactions with valid/ready handshakes on both the request and response channels.
- Exactly one transaction is outstanding at a time. The grant is held from request acceptance until the response handshake completes.

---
 rtl/mem_bus_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one memory port between the IFU (read-only) and the LSU (read/write), one transaction at a time.
// Latency: 1 cycle arbitration (IDLE) + >=1 cycle request (REQ) + >=1 cycle response (RESP); at most one transfer per 3 cycles.
// Backpressure: req/resp ready of the granted master follow the memory / master ready directly; the other master sees ready=0.
// Optional build macro ARB_RR_EN: round-robin arbitration instead of fixed LSU-over-IFU priority.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_W-1:0]     m_rdata,
    output logic                  s_req_valid,
    input  logic                  s_req_ready,
    output logic [ADDR_W-1:0]     s_addr,
    output logic                  s_wen,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wmask,
    input  logic                  s_resp_valid,
    output logic                  s_resp_ready,
    input  logic [DATA_W-1:0]     s_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   grant;        // 0 = IFU, 1 = LSU
    logic   grant_nxt;
    logic   pick_lsu;
    logic   gnt_req_valid;

`ifdef ARB_RR_EN
    logic last_grant;     // master that most recently had its request accepted

    // Round-robin pick: on a tie the master not served last wins; a lone requester always wins.
    always_comb begin
        pick_lsu = lsu_req_valid;
        if (ifu_req_valid && lsu_req_valid) begin
            pick_lsu = ~last_grant;
        end
    end

    // Remember who was served, updated on every accepted memory request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b0;
        end else if (s_req_valid && s_req_ready) begin
            last_grant <= grant;
        end
    end
`else
    // Fixed priority: the LSU wins whenever it is requesting.
    always_comb begin
        pick_lsu = lsu_req_valid;
    end
`endif

    // State and grant registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    // Next-state logic and the grant-steered muxes on both channels.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        m_rdata        = '0;
        s_req_valid    = 1'b0;
        s_addr         = '0;
        s_wen          = 1'b0;
        s_wdata        = '0;
        s_wmask        = '0;
        s_resp_ready   = 1'b0;
        gnt_req_valid  = grant ? lsu_req_valid : ifu_req_valid;

        case (state)
            IDLE: begin
                // Decision cycle: nothing is accepted here, the grant is only latched.
                if (ifu_req_valid || lsu_req_valid) begin
                    grant_nxt = pick_lsu;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                s_req_valid = gnt_req_valid;
                if (grant) begin
                    s_addr        = lsu_addr;
                    s_wen         = lsu_wen;
                    s_wdata       = lsu_wdata;
                    s_wmask       = lsu_wmask;
                    lsu_req_ready = s_req_ready;
                end else begin
                    s_addr        = ifu_addr;
                    ifu_req_ready = s_req_ready;
                end
                if (gnt_req_valid && s_req_ready) begin
                    state_nxt = RESP;
                end else if (!gnt_req_valid) begin
                    // A master withdrew its request before acceptance; re-arbitrate.
                    state_nxt = IDLE;
                end
            end
            RESP: begin
                m_rdata        = s_rdata;
                ifu_resp_valid = ~grant & s_resp_valid;
                lsu_resp_valid = grant & s_resp_valid;
                s_resp_ready   = grant ? lsu_resp_ready : ifu_resp_ready;
                if (s_resp_valid && s_resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
